// File: rtl/aes_rkey_store.sv
// aes_rkey_store
// Round-key buffer for the AES-256 datapath. The key schedule writes the 15
// round keys as 256-bit pairs, and the buffer replays them one 128-bit key per
// cycle to the round engine. Forward order (RK0..RK14) is for encryption and
// reverse order (RK14..RK0) is for decryption.
//
// Ports
//   inClk        clock, rising edge
//   inRst        asynchronous active-high reset
//   inKeyWr      write strobe, one key pair per high cycle
//   inKeyData    [255:128] = RK(2p), [127:0] = RK(2p+1) for write number p
//   inRdStart    read request pulse
//   inRdDir      read direction, sampled with inRdStart (0 fwd, 1 reverse)
//   outKey       current round key (0 when not valid)
//   outKeyIdx    index of outKey (0 when not valid)
//   outKeyValid  outKey/outKeyIdx valid this cycle
//   outReady     all keys loaded, store readable
//   outBusy      load or read in progress
//
// state | meaning
// EMPTY | nothing loaded since reset; reads ignored
// LOAD  | pairs arriving, wrPtr = next pair number
// FULL  | all keys stored, idle, waiting for a read or a new load
// READ  | streaming RK[rdIdx], one key per cycle

module aes_rkey_store #(
  parameter int NKEYS = 15,
  parameter int KW    = 128
) (
  input  logic            inClk,
  input  logic            inRst,
  input  logic            inKeyWr,
  input  logic [2*KW-1:0] inKeyData,
  input  logic            inRdStart,
  input  logic            inRdDir,
  output logic [KW-1:0]   outKey,
  output logic [3:0]      outKeyIdx,
  output logic            outKeyValid,
  output logic            outReady,
  output logic            outBusy
);

  typedef enum logic [1:0] {EMPTY, LOAD, FULL, READ} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NKEYS - 1);

  state_t        state;
  logic [KW-1:0] rk [NKEYS];
  logic [2:0]    wrPtr;
  logic [3:0]    rdIdx;
  logic          rdDir;

  logic [3:0] wrIdxHi;
  logic [3:0] wrIdxLo;
  logic [3:0] startIdx;
  logic [3:0] termIdx;
  logic [3:0] nextIdx;
  logic       loadWr;
  logic       startRd;

  assign wrIdxHi  = {wrPtr, 1'b0};
  assign wrIdxLo  = {wrPtr, 1'b1};
  assign startIdx = inRdDir ? LAST_IDX : 4'd0;
  assign termIdx  = rdDir ? 4'd0 : LAST_IDX;
  assign nextIdx  = rdDir ? (rdIdx - 4'd1) : (rdIdx + 4'd1);

  // EMPTY and FULL hold wrPtr at 0, so a strobe there naturally writes pair 0
  // and (re)starts a load; a write in FULL beats a simultaneous read request.
  assign loadWr = inKeyWr && (state != READ);

  // A start is also taken on the edge that retires the terminal key, so a
  // back-to-back stream has no bubble.
  assign startRd = inRdStart &&
                   (((state == FULL) && !inKeyWr) ||
                    ((state == READ) && (rdIdx == termIdx)));

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state       <= EMPTY;
      wrPtr       <= '0;
      rdIdx       <= '0;
      rdDir       <= 1'b0;
      outKey      <= '0;
      outKeyIdx   <= '0;
      outKeyValid <= 1'b0;
      outReady    <= 1'b0;
      outBusy     <= 1'b0;
      for (int i = 0; i < NKEYS; i++) rk[i] <= '0;
    end else if (loadWr) begin
      // On the last pair the low-half index is 15, which matches no register,
      // so the spare half of the final write is dropped.
      for (int i = 0; i < NKEYS; i++) begin
        if (4'(i) == wrIdxHi) rk[i] <= inKeyData[2*KW-1:KW];
        if (4'(i) == wrIdxLo) rk[i] <= inKeyData[KW-1:0];
      end
      if (wrPtr == 3'd7) begin
        state    <= FULL;
        wrPtr    <= '0;
        outReady <= 1'b1;
        outBusy  <= 1'b0;
      end else begin
        state    <= LOAD;
        wrPtr    <= wrPtr + 3'd1;
        outReady <= 1'b0;
        outBusy  <= 1'b1;
      end
    end else if (startRd) begin
      state       <= READ;
      rdDir       <= inRdDir;
      rdIdx       <= startIdx;
      outKey      <= rk[startIdx];
      outKeyIdx   <= startIdx;
      outKeyValid <= 1'b1;
      outBusy     <= 1'b1;
    end else if (state == READ) begin
      if (rdIdx == termIdx) begin
        state       <= FULL;
        rdIdx       <= '0;
        outKey      <= '0;
        outKeyIdx   <= '0;
        outKeyValid <= 1'b0;
        outBusy     <= 1'b0;
      end else begin
        rdIdx     <= nextIdx;
        outKey    <= rk[nextIdx];
        outKeyIdx <= nextIdx;
      end
    end
  end

endmodule

// File: tb/tb_aes_rkey_store.sv
// Directed bench for aes_rkey_store using the FIPS-197 AES-256 key schedule
// for key 000102..1f. Expected read streams live in a vector table; load,
// back-to-back, partial-load and reset corner cases are hand-written sequences.

module tb_aes_rkey_store;

  typedef struct {
    logic         dir;
    logic [3:0]   expIdx;
    logic [127:0] expKey;
  } readVec_t;

  logic         inClk;
  logic         inRst;
  logic         inKeyWr;
  logic [255:0] inKeyData;
  logic         inRdStart;
  logic         inRdDir;
  logic [127:0] outKey;
  logic [3:0]   outKeyIdx;
  logic         outKeyValid;
  logic         outReady;
  logic         outBusy;

  int nChecks = 0;
  int nFails  = 0;

  logic [127:0] rkExp [15];
  readVec_t     vecs [30];

  localparam logic [127:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  aes_rkey_store #(.NKEYS(15), .KW(128)) dut (
    .inClk      (inClk),
    .inRst      (inRst),
    .inKeyWr    (inKeyWr),
    .inKeyData  (inKeyData),
    .inRdStart  (inRdStart),
    .inRdDir    (inRdDir),
    .outKey     (outKey),
    .outKeyIdx  (outKeyIdx),
    .outKeyValid(outKeyValid),
    .outReady   (outReady),
    .outBusy    (outBusy)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic writePair(input int p);
    inKeyData = {rkExp[2*p], (p == 7) ? JUNK : rkExp[2*p+1]};
    inKeyWr   = 1'b1;
    tick();
    inKeyWr   = 1'b0;
    inKeyData = '0;
  endtask

  task automatic startRead(input logic dir);
    inRdDir   = dir;
    inRdStart = 1'b1;
    tick();
    inRdStart = 1'b0;
    inRdDir   = ~dir;
  endtask

  // Checks a stream already started; optionally pulses a start mid-stream
  // (must be ignored) and/or on the terminal cycle (must chain with no gap).
  task automatic streamCheck(input logic dir, input bit chainNext, input int midPulse);
    int base;
    base = dir ? 15 : 0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("valid d%0d k%0d", dir, i), {127'd0, outKeyValid}, 128'd1);
      chk($sformatf("idx d%0d k%0d", dir, i), {124'd0, outKeyIdx}, {124'd0, vecs[base+i].expIdx});
      chk($sformatf("key d%0d k%0d", dir, i), outKey, vecs[base+i].expKey);
      if (i == 0) chk("busy in stream", {127'd0, outBusy}, 128'd1);
      if (i == midPulse) begin
        inRdStart = 1'b1;
        inRdDir   = ~dir;
      end
      if (i == 14 && chainNext) begin
        inRdStart = 1'b1;
        inRdDir   = dir;
      end
      tick();
      inRdStart = 1'b0;
      inRdDir   = ~dir;
    end
    if (!chainNext) begin
      chk("valid after stream", {127'd0, outKeyValid}, 128'd0);
      chk("idx after stream", {124'd0, outKeyIdx}, 128'd0);
      chk("key after stream", outKey, 128'd0);
      chk("busy after stream", {127'd0, outBusy}, 128'd0);
      chk("ready after stream", {127'd0, outReady}, 128'd1);
    end
  endtask

  task automatic checkIdleZero(input string tag, input logic expReady, input logic expBusy);
    chk({tag, " valid"}, {127'd0, outKeyValid}, 128'd0);
    chk({tag, " key"}, outKey, 128'd0);
    chk({tag, " idx"}, {124'd0, outKeyIdx}, 128'd0);
    chk({tag, " ready"}, {127'd0, outReady}, {127'd0, expReady});
    chk({tag, " busy"}, {127'd0, outBusy}, {127'd0, expBusy});
  endtask

  initial begin
    rkExp[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rkExp[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    rkExp[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    rkExp[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    rkExp[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    rkExp[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    rkExp[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    rkExp[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    rkExp[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    rkExp[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    rkExp[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    rkExp[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    rkExp[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    rkExp[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    rkExp[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    for (int i = 0; i < 15; i++) begin
      vecs[i]    = '{dir: 1'b0, expIdx: 4'(i),      expKey: rkExp[i]};
      vecs[15+i] = '{dir: 1'b1, expIdx: 4'(14 - i), expKey: rkExp[14-i]};
    end

    inRst     = 1'b1;
    inKeyWr   = 1'b0;
    inKeyData = '0;
    inRdStart = 1'b0;
    inRdDir   = 1'b0;
    repeat (3) tick();
    checkIdleZero("reset", 1'b0, 1'b0);
    inRst = 1'b0;
    tick();

    // Reads in EMPTY do nothing.
    startRead(1'b0);
    checkIdleZero("empty read", 1'b0, 1'b0);
    startRead(1'b1);
    tick();
    checkIdleZero("empty read2", 1'b0, 1'b0);

    // Full load with 2-cycle gaps.
    for (int p = 0; p < 8; p++) begin
      writePair(p);
      if (p == 0) begin
        chk("busy after 1st wr", {127'd0, outBusy}, 128'd1);
        chk("ready after 1st wr", {127'd0, outReady}, 128'd0);
      end
      if (p == 6) chk("ready after 7th wr", {127'd0, outReady}, 128'd0);
      if (p == 7) begin
        chk("ready after 8th wr", {127'd0, outReady}, 128'd1);
        chk("busy after 8th wr", {127'd0, outBusy}, 128'd0);
      end
      repeat (2) tick();
    end

    // Forward read; RK14 must not carry the discarded half, no 16th key.
    startRead(1'b0);
    streamCheck(1'b0, 1'b0, -1);
    tick();

    // Reverse read with an ignored mid-stream start, then a chained restart.
    startRead(1'b1);
    streamCheck(1'b1, 1'b1, 6);
    streamCheck(1'b1, 1'b0, -1);
    tick();
    chk("no stray stream", {127'd0, outKeyValid}, 128'd0);

    // Write and read together in FULL: write wins, new load starts.
    inRdStart = 1'b1;
    inRdDir   = 1'b0;
    writePair(0);
    inRdStart = 1'b0;
    checkIdleZero("wr beats rd", 1'b0, 1'b1);
    for (int p = 1; p < 5; p++) writePair(p);
    startRead(1'b0);
    checkIdleZero("partial read", 1'b0, 1'b1);
    tick();
    chk("partial no valid", {127'd0, outKeyValid}, 128'd0);
    for (int p = 5; p < 8; p++) begin
      writePair(p);
      if (p == 6) chk("partial ready 7th", {127'd0, outReady}, 128'd0);
    end
    chk("partial ready 8th", {127'd0, outReady}, 128'd1);
    chk("partial busy 8th", {127'd0, outBusy}, 128'd0);

    // Reset in the middle of a read, at the 7th key.
    startRead(1'b0);
    repeat (6) tick();
    chk("pre-reset idx", {124'd0, outKeyIdx}, 128'd6);
    chk("pre-reset valid", {127'd0, outKeyValid}, 128'd1);
    #2;
    inRst = 1'b1;
    #1;
    checkIdleZero("async reset", 1'b0, 1'b0);
    tick();
    inRst = 1'b0;
    tick();
    startRead(1'b0);
    checkIdleZero("read after reset", 1'b0, 1'b0);
    repeat (3) tick();
    chk("still no valid", {127'd0, outKeyValid}, 128'd0);

    // Reload and confirm the store works again.
    for (int p = 0; p < 8; p++) writePair(p);
    chk("reload ready", {127'd0, outReady}, 128'd1);
    startRead(1'b0);
    streamCheck(1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
